// File: rtl/apb3_arbiter_if.sv
// ---------------------------------------------------------------------------
// apb3_arbiter_if
//   APB3 bus bundle carrying N parallel ports. The requester side of the
//   arbiter uses N = NUM_REQ and the shared master side uses N = 1.
//   master modport : drives paddr/psel/penable/pwrite/pwdata, receives
//                    pready/prdata/pslverror.
//   slave modport  : the reverse view.
// ---------------------------------------------------------------------------
interface apb3_arbiter_if #(
  parameter int APB_AW = 20,
  parameter int APB_DW = 32,
  parameter int N      = 1
);
  logic [N-1:0][APB_AW-1:0] paddr;
  logic [N-1:0]             psel;
  logic [N-1:0]             penable;
  logic [N-1:0]             pwrite;
  logic [N-1:0][APB_DW-1:0] pwdata;
  logic [N-1:0]             pready;
  logic [N-1:0][APB_DW-1:0] prdata;
  logic [N-1:0]             pslverror;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  pready, prdata, pslverror
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output pready, prdata, pslverror
  );
endinterface

// File: rtl/apb3_arbiter.sv
// ---------------------------------------------------------------------------
// apb3_arbiter
//   Round-robin arbiter sharing one APB3 master port among NUM_REQ APB3
//   requesters. The winning request is registered, the SETUP/ACCESS sequence
//   is run on the master port, and the response is routed back to the winner
//   only. A PREADY watchdog forces an error completion on a hung slave.
//
//   Ports
//     clk    : clock, rising edge
//     rst_n  : synchronous active-low reset
//     s_apb  : requester side (slave modport, NUM_REQ lanes)
//     m_apb  : shared master side (master modport, one lane)
// ---------------------------------------------------------------------------

// Per-requester response steering. hit_i is high only for the granted lane
// in its completion cycle; rsp_i says the slave (not the watchdog) finished.
module apb3_arbiter_lane #(
  parameter int APB_DW = 32
) (
  input  logic              hit_i,
  input  logic              rsp_i,
  input  logic [APB_DW-1:0] prdata_i,
  input  logic              pslverror_i,
  output logic              pready_o,
  output logic [APB_DW-1:0] prdata_o,
  output logic              pslverror_o
);
  assign pready_o    = hit_i;
  assign prdata_o    = (hit_i && rsp_i) ? prdata_i : '0;
  // watchdog completion always reports an error
  assign pslverror_o = hit_i && (rsp_i ? pslverror_i : 1'b1);
endmodule

module apb3_arbiter #(
  parameter int APB_AW         = 20,
  parameter int APB_DW         = 32,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  apb3_arbiter_if.slave  s_apb,
  apb3_arbiter_if.master m_apb
);
  localparam int SEL_WID = $clog2(NUM_REQ);
  localparam int TMO_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  typedef struct packed {
    logic [APB_AW-1:0] addr;
    logic              write;
    logic [APB_DW-1:0] wdata;
  } req_t;

  state_e             state_q, state_d;
  logic [SEL_WID-1:0] grant_q, grant_d;
  logic [SEL_WID-1:0] rr_ptr_q, rr_ptr_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  req_t               req_q, req_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;

  logic               any_req;
  logic [SEL_WID-1:0] winner;
  logic               tmo_hit;
  logic               done;

  logic [NUM_REQ-1:0]             pready_w;
  logic [NUM_REQ-1:0][APB_DW-1:0] prdata_w;
  logic [NUM_REQ-1:0]             pslverr_w;

  // requester penable plays no part in arbitration
  logic unused_penable;
  assign unused_penable = ^s_apb.penable;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    logic [SEL_WID-1:0] cand;
    cand    = '0;
    winner  = rr_ptr_q;
    any_req = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = SEL_WID'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!any_req && s_apb.psel[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  assign tmo_hit = (TIMEOUT_CYCLES > 0) && (tmo_q == TMO_LAST);
  // slave pready takes precedence over a simultaneous watchdog expiry
  assign done    = (state_q == ACCESS) && (m_apb.pready[0] || tmo_hit);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    tmo_d     = tmo_q;
    req_d     = req_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d       = winner;
          req_d.addr    = s_apb.paddr[winner];
          req_d.write   = s_apb.pwrite[winner];
          req_d.wdata   = s_apb.pwdata[winner];
          psel_d        = 1'b1;
          state_d       = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        tmo_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (done) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          rr_ptr_d  = grant_q;
          state_d   = IDLE;
        end else if (tmo_q != {TMO_W{1'b1}}) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= SEL_WID'(NUM_REQ - 1);
      tmo_q     <= '0;
      req_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      tmo_q     <= tmo_d;
      req_q     <= req_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
    end
  end

  assign m_apb.paddr[0]   = req_q.addr;
  assign m_apb.pwrite[0]  = req_q.write;
  assign m_apb.pwdata[0]  = req_q.wdata;
  assign m_apb.psel[0]    = psel_q;
  assign m_apb.penable[0] = penable_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    apb3_arbiter_lane #(.APB_DW(APB_DW)) u_lane (
      .hit_i       (done && (grant_q == SEL_WID'(i))),
      .rsp_i       (m_apb.pready[0]),
      .prdata_i    (m_apb.prdata[0]),
      .pslverror_i (m_apb.pslverror[0]),
      .pready_o    (pready_w[i]),
      .prdata_o    (prdata_w[i]),
      .pslverror_o (pslverr_w[i])
    );
  end

  assign s_apb.pready    = pready_w;
  assign s_apb.prdata    = prdata_w;
  assign s_apb.pslverror = pslverr_w;
endmodule

// File: tb/tb_apb3_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb3_arbiter
//   Self-checking bench for apb3_arbiter. A slave BFM answers each transfer
//   and records what the requester side saw; each scenario task compares the
//   record against a transaction-level model (round-robin by distance from
//   the last grant, completion at min(slave ready, watchdog)).
// ---------------------------------------------------------------------------
module tb_apb3_arbiter;
  localparam int AW  = 20;
  localparam int DW  = 32;
  localparam int NR  = 4;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb3_arbiter_if #(.APB_AW(AW), .APB_DW(DW), .N(NR)) s_bus ();
  apb3_arbiter_if #(.APB_AW(AW), .APB_DW(DW), .N(1))  m_bus ();

  apb3_arbiter #(
    .APB_AW(AW), .APB_DW(DW), .NUM_REQ(NR), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_apb (s_bus),
    .m_apb (m_bus)
  );

  typedef struct {
    int          lat;
    int          win;
    int          cyc;
    int          npr;
    logic [DW-1:0] rd;
    logic        er;
    logic [AW-1:0] addr;
    logic        wr;
    logic [DW-1:0] wd;
    bit          stable;
    bit          clean;
    bit          idle;
  } obs_t;

  int n_tests = 0;
  int n_fail  = 0;
  int rr;                       // model: last granted requester
  logic [AW-1:0] req_addr [NR];
  logic [DW-1:0] req_wd   [NR];
  logic          req_wr   [NR];

  // winner = requesting index nearest after the last grant, going upward
  function automatic int pick(input logic [NR-1:0] mask, input int last);
    int best, bd, d;
    best = -1;
    bd   = NR;
    for (int i = 0; i < NR; i++) begin
      if (mask[i]) begin
        d = (i - last - 1 + 2 * NR) % NR;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic drive_reqs(input logic [NR-1:0] mask);
    for (int i = 0; i < NR; i++) begin
      s_bus.paddr[i]  = req_addr[i];
      s_bus.pwdata[i] = req_wd[i];
      s_bus.pwrite[i] = req_wr[i];
    end
    s_bus.psel    = mask;
    s_bus.penable = mask;
  endtask

  // Slave BFM: called during an IDLE cycle. Waits for SETUP, then raises
  // pready on ACCESS cycle wait_n+1 and records the requester-side view.
  task automatic slave_xfer(input int wait_n, input logic [DW-1:0] rd,
                            input logic er, input bit scram, output obs_t o);
    bit hit;
    o.lat = 0; o.win = -1; o.cyc = 0; o.npr = 0; o.rd = '0; o.er = 1'b0;
    o.addr = '0; o.wr = 1'b0; o.wd = '0; o.stable = 1; o.clean = 1; o.idle = 0;
    hit = 0;
    while (!hit && o.lat < 16) begin
      @(posedge clk); #1;
      o.lat++;
      hit = m_bus.psel[0] && !m_bus.penable[0];
      if (s_bus.pready != '0) o.clean = 0;
    end
    if (!hit) return;
    o.addr = m_bus.paddr[0];
    o.wr   = m_bus.pwrite[0];
    o.wd   = m_bus.pwdata[0];
    for (int k = 1; k <= 40 && o.cyc == 0; k++) begin
      @(posedge clk); #1;
      m_bus.pready[0]    = (k == wait_n + 1);
      m_bus.prdata[0]    = (k == wait_n + 1) ? rd : DW'($urandom);
      m_bus.pslverror[0] = (k == wait_n + 1) ? er : 1'($urandom);
      if (scram) begin
        for (int i = 0; i < NR; i++) begin
          s_bus.paddr[i]  = AW'($urandom);
          s_bus.pwdata[i] = DW'($urandom);
        end
      end
      #1;
      if (!(m_bus.psel[0] && m_bus.penable[0] && m_bus.paddr[0] == o.addr &&
            m_bus.pwrite[0] == o.wr && m_bus.pwdata[0] == o.wd)) o.stable = 0;
      if (s_bus.pready != '0) begin
        o.npr++;
        o.cyc = k;
        if ($countones(s_bus.pready) != 1) o.clean = 0;
        for (int i = 0; i < NR; i++) begin
          if (s_bus.pready[i]) begin
            o.win = i;
            o.rd  = s_bus.prdata[i];
            o.er  = s_bus.pslverror[i];
          end else if (s_bus.prdata[i] != '0 || s_bus.pslverror[i]) begin
            o.clean = 0;
          end
        end
      end else if (s_bus.prdata != '0 || s_bus.pslverror != '0) begin
        o.clean = 0;
      end
    end
    @(posedge clk); #1;
    m_bus.pready[0]    = 1'b0;
    m_bus.prdata[0]    = '0;
    m_bus.pslverror[0] = 1'b0;
    for (int i = 0; i < NR; i++) begin
      s_bus.paddr[i]  = req_addr[i];
      s_bus.pwdata[i] = req_wd[i];
    end
    #1;
    if (s_bus.pready != '0) o.npr++;
    o.idle = !m_bus.psel[0] && !m_bus.penable[0];
  endtask

  task automatic test_reset();
    for (int i = 0; i < NR; i++) begin
      req_addr[i] = AW'(32'h100 * (i + 1) + i);
      req_wd[i]   = 32'hC0DE_0000 + i;
      req_wr[i]   = i[0];
    end
    rst_n = 1'b0;
    drive_reqs('1);
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (m_bus.psel[0] !== 1'b0 || m_bus.penable[0] !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: psel=%b penable=%b want 0 0", m_bus.psel[0], m_bus.penable[0]);
    end
    n_tests++;
    if (m_bus.paddr[0] !== '0 || m_bus.pwrite[0] !== 1'b0 || m_bus.pwdata[0] !== '0) begin
      n_fail++; $display("FAIL reset_bus: addr=%h wr=%b wd=%h want 0", m_bus.paddr[0], m_bus.pwrite[0], m_bus.pwdata[0]);
    end
    n_tests++;
    if (s_bus.pready !== '0) begin
      n_fail++; $display("FAIL reset_pready: got %b want 0", s_bus.pready);
    end
  endtask

  // all four request continuously from reset release
  task automatic test_contention();
    obs_t o;
    int   exp;
    rst_n = 1'b1;
    rr = NR - 1;
    for (int t = 0; t < 5; t++) begin
      exp = pick('1, rr);
      slave_xfer(0, DW'($urandom), 1'b0, 0, o);
      n_tests++;
      if (o.win !== exp || o.addr !== req_addr[exp]) begin
        n_fail++; $display("FAIL contention_grant[%0d]: got %0d addr %h want %0d addr %h", t, o.win, o.addr, exp, req_addr[exp]);
      end
      n_tests++;
      if (o.lat !== 1 || o.cyc !== 1 || o.npr !== 1 || !o.idle) begin
        n_fail++; $display("FAIL contention_timing[%0d]: lat %0d cyc %0d npr %0d idle %0d want 1 1 1 1", t, o.lat, o.cyc, o.npr, o.idle);
      end
      rr = exp;
    end
  endtask

  task automatic test_single_write();
    obs_t o;
    req_addr[1] = 20'h00123;
    req_wd[1]   = 32'hDEAD_BEEF;
    req_wr[1]   = 1'b1;
    drive_reqs(4'b0010);
    slave_xfer(0, '0, 1'b0, 0, o);
    drive_reqs('0);
    rr = 1;
    n_tests++;
    if (o.win !== 1 || o.lat !== 1 || o.cyc !== 1) begin
      n_fail++; $display("FAIL single_timing: win %0d lat %0d cyc %0d want 1 1 1", o.win, o.lat, o.cyc);
    end
    n_tests++;
    if (o.addr !== 20'h00123 || o.wr !== 1'b1 || o.wd !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL single_bus: addr %h wr %b wd %h want 00123 1 deadbeef", o.addr, o.wr, o.wd);
    end
    n_tests++;
    if (!o.clean || o.npr !== 1 || !o.idle) begin
      n_fail++; $display("FAIL single_resp: clean %0d npr %0d idle %0d want 1 1 1", o.clean, o.npr, o.idle);
    end
  endtask

  task automatic test_wait_states();
    obs_t o;
    req_addr[2] = 20'hA_BCDE;
    req_wr[2]   = 1'b0;
    drive_reqs(4'b0100);
    slave_xfer(5, 32'hA5A5_A5A5, 1'b0, 1, o);
    drive_reqs('0);
    rr = 2;
    n_tests++;
    if (o.win !== 2 || o.cyc !== 6 || o.npr !== 1) begin
      n_fail++; $display("FAIL wait_timing: win %0d cyc %0d npr %0d want 2 6 1", o.win, o.cyc, o.npr);
    end
    n_tests++;
    if (o.rd !== 32'hA5A5_A5A5 || o.er !== 1'b0) begin
      n_fail++; $display("FAIL wait_data: rd %h er %b want a5a5a5a5 0", o.rd, o.er);
    end
    n_tests++;
    if (!o.stable || o.addr !== 20'hA_BCDE || !o.clean) begin
      n_fail++; $display("FAIL wait_stable: stable %0d addr %h clean %0d want 1 abcde 1", o.stable, o.addr, o.clean);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    drive_reqs(4'b1001);
    slave_xfer(1000, 32'h1234_5678, 1'b0, 0, o);
    drive_reqs(4'b0001);
    n_tests++;
    if (o.win !== pick(4'b1001, rr) || o.cyc !== TMO || o.npr !== 1) begin
      n_fail++; $display("FAIL timeout_timing: win %0d cyc %0d npr %0d want %0d %0d 1", o.win, o.cyc, o.npr, pick(4'b1001, rr), TMO);
    end
    n_tests++;
    if (o.er !== 1'b1 || o.rd !== '0 || !o.clean) begin
      n_fail++; $display("FAIL timeout_resp: er %b rd %h clean %0d want 1 0 1", o.er, o.rd, o.clean);
    end
    rr = 3;
    slave_xfer(2, 32'h0F0F_1234, 1'b1, 0, o);
    drive_reqs('0);
    rr = 0;
    n_tests++;
    if (o.win !== 0 || o.cyc !== 3 || o.er !== 1'b1 || o.rd !== 32'h0F0F_1234) begin
      n_fail++; $display("FAIL timeout_next: win %0d cyc %0d er %b rd %h want 0 3 1 0f0f1234", o.win, o.cyc, o.er, o.rd);
    end
  endtask

  task automatic test_tie();
    obs_t o;
    drive_reqs(4'b0100);
    slave_xfer(TMO - 1, 32'h5A5A_0001, 1'b0, 0, o);
    drive_reqs('0);
    rr = 2;
    n_tests++;
    if (o.win !== 2 || o.cyc !== TMO || o.er !== 1'b0 || o.rd !== 32'h5A5A_0001) begin
      n_fail++; $display("FAIL tie: win %0d cyc %0d er %b rd %h want 2 %0d 0 5a5a0001", o.win, o.cyc, o.er, o.rd, TMO);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    drive_reqs(4'b1000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_tests++;
    if (m_bus.psel[0] !== 1'b1 || m_bus.penable[0] !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_access: psel %b penable %b want 1 1", m_bus.psel[0], m_bus.penable[0]);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (s_bus.pready !== '0) begin
      n_fail++; $display("FAIL rstmid_pready_pre: got %b want 0", s_bus.pready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (m_bus.psel[0] !== 1'b0 || m_bus.penable[0] !== 1'b0 || s_bus.pready !== '0) begin
      n_fail++; $display("FAIL rstmid_abort: psel %b penable %b pready %b want 0 0 0", m_bus.psel[0], m_bus.penable[0], s_bus.pready);
    end
    rst_n = 1'b1;
    rr = NR - 1;
    drive_reqs('1);
    slave_xfer(0, 32'h0BAD_F00D, 1'b0, 0, o);
    drive_reqs('0);
    n_tests++;
    if (o.win !== pick('1, rr) || o.lat !== 1 || o.rd !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL rstmid_first: win %0d lat %0d rd %h want %0d 1 0badf00d", o.win, o.lat, o.rd, pick('1, rr));
    end
    rr = pick('1, rr);
  endtask

  task automatic test_random();
    obs_t o;
    logic [NR-1:0] mask;
    logic [DW-1:0] rd;
    logic er;
    int w, exp, ecyc;
    bit slv;
    for (int t = 0; t < 40; t++) begin
      drive_reqs('0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        req_addr[i] = AW'($urandom);
        req_wd[i]   = DW'($urandom);
        req_wr[i]   = 1'($urandom);
      end
      mask = NR'($urandom_range(1, (1 << NR) - 1));
      w    = $urandom_range(0, 10);
      rd   = DW'($urandom);
      er   = 1'($urandom);
      exp  = pick(mask, rr);
      slv  = (w + 1 <= TMO);
      ecyc = slv ? w + 1 : TMO;
      drive_reqs(mask);
      slave_xfer(w, rd, er, 1'($urandom), o);
      n_tests++;
      if (o.win !== exp || o.lat !== 1 || o.cyc !== ecyc || o.npr !== 1) begin
        n_fail++; $display("FAIL rand_timing[%0d]: win %0d lat %0d cyc %0d npr %0d want %0d 1 %0d 1", t, o.win, o.lat, o.cyc, o.npr, exp, ecyc);
      end
      n_tests++;
      if (o.addr !== req_addr[exp] || o.wr !== req_wr[exp] || o.wd !== req_wd[exp] || !o.stable) begin
        n_fail++; $display("FAIL rand_bus[%0d]: addr %h wr %b wd %h stable %0d want %h %b %h 1", t, o.addr, o.wr, o.wd, o.stable, req_addr[exp], req_wr[exp], req_wd[exp]);
      end
      n_tests++;
      if (o.rd !== (slv ? rd : '0) || o.er !== (slv ? er : 1'b1) || !o.clean || !o.idle) begin
        n_fail++; $display("FAIL rand_resp[%0d]: rd %h er %b clean %0d idle %0d want %h %b 1 1", t, o.rd, o.er, o.clean, o.idle, slv ? rd : '0, slv ? er : 1'b1);
      end
      rr = exp;
    end
    drive_reqs('0);
  endtask

  initial begin
    s_bus.paddr = '0; s_bus.psel = '0; s_bus.penable = '0;
    s_bus.pwrite = '0; s_bus.pwdata = '0;
    m_bus.pready = '0; m_bus.prdata = '0; m_bus.pslverror = '0;
    test_reset();
    test_contention();
    test_single_write();
    test_wait_states();
    test_timeout();
    test_tie();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
